// File: rtl/uart_pkg.sv
// Shared UART constants, beat type and small helpers used by the receive-side
// blocks. Optional build macro seen by users of this package:
// UART_RX_FRAMER_STATS_EN (enables packet/error/drop counters in the framer).
package uart_pkg;

  // Receiver samples each bit this many times per prescale unit.
  localparam int unsigned UART_OVERSAMPLE = 8;

  // Wide enough for 16-bit prescale * 8 * 8-bit idle_bits without truncation.
  localparam int unsigned UART_IDLE_TIMER_W = 27;

  // One output beat at the receiver's native byte width.
  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } uart_beat_t;

  // Saturating 16-bit increment for statistics counters.
  function automatic logic [15:0] uart_sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Line-idle timer for the UART receive framer. Counts cycles while the line
// is idle and a byte is waiting; reports expiry one cycle before the full
// idle gap (prescale * 8 * idle_bits cycles) so the caller's registered
// output lands exactly on the gap boundary. A zero-length gap is always
// expired.
module uart_idle_timer
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] prescale_i,
  input  logic [7:0]  idle_bits_i,
  input  logic        run_i,
  input  logic        clear_i,
  output logic        expired_o
);

  localparam int unsigned TW = UART_IDLE_TIMER_W;

  logic [TW-1:0] limit_s;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;

  // Idle gap length in clock cycles, computed at full timer width.
  always_comb begin
    limit_s = TW'(prescale_i) * TW'(idle_bits_i) * TW'(UART_OVERSAMPLE);
  end

  // Expiry compare; a zero limit means every held byte closes immediately.
  always_comb begin
    if (limit_s == TW'(0)) begin
      expired_o = 1'b1;
    end else if (timer_q >= (limit_s - TW'(1))) begin
      expired_o = 1'b1;
    end else begin
      expired_o = 1'b0;
    end
  end

  // Next count: clear wins, otherwise count up and stick once expired.
  always_comb begin
    timer_d = timer_q;
    if (clear_i) begin
      timer_d = TW'(0);
    end else if (run_i && !expired_o) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = timer_q;
    end
  end

  // Timer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= TW'(0);
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive framer: groups received bytes into AXI4-Stream packets that
// close on a line-idle gap or on MAX_LEN beats. One byte is always held back
// so the framer knows, when it releases it, whether it ends the packet.
// Optional build macro: UART_RX_FRAMER_STATS_EN adds pkt_count, err_count
// and drop_count outputs (saturating 16-bit counters).
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  rx_busy,
  input  logic                  rx_frame_error,
  input  logic                  rx_overrun_error,
  input  logic [15:0]           prescale,
  input  logic [7:0]            idle_bits,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy
`ifdef UART_RX_FRAMER_STATS_EN
  ,
  output logic [15:0]           pkt_count,
  output logic [15:0]           err_count,
  output logic [15:0]           drop_count
`endif
);

  localparam int LEN_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(MAX_LEN - 1);

  // Hold stage
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_valid_q, hold_valid_d;
  // Output stage
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  out_user_q, out_user_d;
  // Packet bookkeeping
  logic [LEN_W-1:0]      len_q, len_d;
  logic                  err_acc_q, err_acc_d;
  logic                  busy_q, busy_d;

  // Control strobes
  logic out_free_s;
  logic s_ready_s;
  logic accept_s;
  logic push_s;
  logic timeout_s;
  logic emit_s;
  logic emit_last_s;
  logic err_pulse_s;
  logic timer_run_s;
  logic timer_clear_s;
  logic expired_s;

  uart_idle_timer u_idle_timer (
    .clk         (clk),
    .rst         (rst),
    .prescale_i  (prescale),
    .idle_bits_i (idle_bits),
    .run_i       (timer_run_s),
    .clear_i     (timer_clear_s),
    .expired_o   (expired_s)
  );

  // Handshake and packet-closing decisions. A new byte always beats a
  // timeout: the held byte is then pushed out as a middle beat.
  always_comb begin
    out_free_s    = !out_valid_q || m_axis_tready;
    s_ready_s     = !hold_valid_q || out_free_s;
    accept_s      = s_axis_tvalid && s_ready_s;
    push_s        = accept_s && hold_valid_q;
    timeout_s     = hold_valid_q && expired_s && out_free_s && !accept_s;
    emit_s        = push_s || timeout_s;
    emit_last_s   = emit_s && (timeout_s || (len_q == LAST_IDX));
    err_pulse_s   = rx_frame_error || rx_overrun_error;
    timer_run_s   = hold_valid_q && !rx_busy && !s_axis_tvalid;
    timer_clear_s = rx_busy || accept_s || timeout_s || !hold_valid_q;
  end

  // Next state for the hold and output stages and packet bookkeeping.
  always_comb begin
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_user_d   = out_user_q;
    len_d        = len_q;
    err_acc_d    = err_acc_q;

    if (accept_s) begin
      hold_data_d  = s_axis_tdata;
      hold_valid_d = 1'b1;
    end else if (timeout_s) begin
      hold_valid_d = 1'b0;
    end else begin
      hold_valid_d = hold_valid_q;
    end

    if (emit_s) begin
      out_data_d  = hold_data_q;
      out_valid_d = 1'b1;
      out_last_d  = emit_last_s;
      // An error pulse in the closing cycle still belongs to this packet.
      out_user_d  = emit_last_s && (err_acc_q || err_pulse_s);
    end else if (out_free_s) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_user_d  = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (emit_s) begin
      if (emit_last_s) begin
        len_d = LEN_W'(0);
      end else begin
        len_d = len_q + LEN_W'(1);
      end
    end else begin
      len_d = len_q;
    end

    if (emit_last_s) begin
      err_acc_d = 1'b0;
    end else if (err_pulse_s) begin
      err_acc_d = 1'b1;
    end else begin
      err_acc_d = err_acc_q;
    end

    busy_d = hold_valid_d || out_valid_d;
  end

  // State registers; reset discards any partially built packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data_q  <= {DATA_WIDTH{1'b0}};
      hold_valid_q <= 1'b0;
      out_data_q   <= {DATA_WIDTH{1'b0}};
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_user_q   <= 1'b0;
      len_q        <= LEN_W'(0);
      err_acc_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_user_q   <= out_user_d;
      len_q        <= len_d;
      err_acc_q    <= err_acc_d;
      busy_q       <= busy_d;
    end
  end

  assign s_axis_tready = s_ready_s;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tuser  = out_user_q;
  assign busy          = busy_q;

`ifdef UART_RX_FRAMER_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        last_hs_s;

  // Statistics counter updates on closing handshakes and refused bytes.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    err_cnt_d  = err_cnt_q;
    drop_cnt_d = drop_cnt_q;
    last_hs_s  = out_valid_q && m_axis_tready && out_last_q;
    if (last_hs_s) begin
      pkt_cnt_d = uart_sat_inc16(pkt_cnt_q);
    end else begin
      pkt_cnt_d = pkt_cnt_q;
    end
    if (last_hs_s && out_user_q) begin
      err_cnt_d = uart_sat_inc16(err_cnt_q);
    end else begin
      err_cnt_d = err_cnt_q;
    end
    if (s_axis_tvalid && !s_ready_s) begin
      drop_cnt_d = uart_sat_inc16(drop_cnt_q);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q  <= 16'd0;
      err_cnt_q  <= 16'd0;
      drop_cnt_q <= 16'd0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pkt_count  = pkt_cnt_q;
  assign err_count  = err_cnt_q;
  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: doc/uart_rx_framer.md
# uart_rx_framer

Packetizer that sits directly downstream of the UART receiver. It consumes the receiver's AXI4-Stream byte output and status pulses, and groups bytes into packets. A packet ends on a programmable line-idle gap or a maximum length. Packets leave on an AXI4-Stream master with `tlast`, plus a `tuser` error flag on the final beat.

## Interface
Parameters:
- `DATA_WIDTH`, 8, byte width; must match the receiver.
- `MAX_LEN`, 256, maximum beats per packet; must be ≥1. Reaching it forces `tlast`.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `s_axis_tdata`  in  DATA_WIDTH  received byte
- `s_axis_tvalid`  in  1  byte valid
- `s_axis_tready`  out  1  byte accepted
- `rx_busy`  in  1  receiver mid-character
- `rx_frame_error`  in  1  one-cycle pulse
- `rx_overrun_error`  in  1  one-cycle pulse
- `prescale`  in  16  same value the receiver uses; one bit time = `prescale*8` cycles
- `idle_bits`  in  8  idle gap, in bit times, that terminates a packet
- `m_axis_tdata`  out  DATA_WIDTH  packet byte
- `m_axis_tvalid`  out  1
- `m_axis_tready`  in  1
- `m_axis_tlast`  out  1  final byte of packet
- `m_axis_tuser`  out  1  packet saw an error; meaningful only with `tlast`
- `busy`  out  1  held byte or output pending

## Operation
- Datapath: one hold register (`hold_data`, `hold_valid`) feeding one output register.
  - `out_free = !m_axis_tvalid || m_axis_tready`.
  - `s_axis_tready = !hold_valid || out_free`.
- Byte accepted while `hold_valid`:
  - The held byte moves to the output with `tlast = (len_cnt == MAX_LEN-1)`.
  - The new byte enters hold.
- Byte accepted with hold empty: the byte enters hold.
- `len_cnt` counts beats emitted in the current packet and clears on any `tlast` beat.
- Idle timer:
  - Counts 27 bits wide; the limit is `prescale*8*idle_bits`, computed at full 27-bit width with no truncation.
  - Increments while `hold_valid && !rx_busy && !s_axis_tvalid`.
  - Clears on `rx_busy`, on byte acceptance, and on hold emptying.
- Timeout: when `timer >= limit-1` and `out_free`, the held byte moves to the output with `tlast=1` and hold empties. If the output is not free, the block waits with the timer saturated.
- `idle_bits == 0` or `prescale == 0`: each held byte is emitted with `tlast=1` on the first cycle `out_free` holds.
- Error accumulation:
  - `err_acc` is set by either error pulse.
  - On a `tlast` beat, `tuser = err_acc | pulse same cycle`, and `err_acc` clears.
  - A pulse in the same cycle as `tlast` belongs to the closing packet.
- Output holds stable while `m_axis_tvalid && !m_axis_tready`.
- `busy = hold_valid | m_axis_tvalid`.

## Timing
- Reset values:
  - `m_axis_tvalid=0`, `m_axis_tdata=0`, `m_axis_tlast=0`, `m_axis_tuser=0`.
  - `s_axis_tready=1`, `busy=0`, hold empty.
  - Timer, `len_cnt` and `err_acc` all 0.
- Reset mid-packet discards the held and output bytes; no partial `tlast` is emitted.
- Latency, non-final byte: `m_axis_tvalid` rises 1 cycle after the next byte is accepted.
- Latency, final byte: `m_axis_tvalid` rises 1 cycle after the idle limit is reached, i.e. `prescale*8*idle_bits` cycles after acceptance with the line idle.
- Full throughput: one beat per cycle when `m_axis_tready=1`.
- Simultaneous timeout and new byte: the new byte wins. The held byte goes out with `tlast=0` (unless `MAX_LEN` is reached) and the new byte is held.

## Configuration
- `UART_RX_FRAMER_STATS_EN` defined adds three outputs:
  - `pkt_count[15:0]`: increments on each `tlast` handshake.
  - `err_count[15:0]`: increments on each `tlast` handshake with `tuser=1`.
  - `drop_count[15:0]`: increments when `s_axis_tvalid && !s_axis_tready`.
- All three counters saturate at 0xFFFF and reset to 0.
- Without the macro these ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Shared package `uart_pkg` holds:
  - `UART_OVERSAMPLE = 8`;
  - the timer width constant `UART_IDLE_TIMER_W = 27`;
  - `typedef struct {data, last, user} uart_beat_t`.
- Natural sub-module: `uart_idle_timer`, which takes `prescale`, `idle_bits`, `run` and `clear` and produces `expired`. It holds the multiply and the saturating counter.

## Test plan
- Three-byte burst, idle: `prescale=1`, `idle_bits=2`, bytes 0x41,0x42,0x43 back-to-back, then idle → beats 41/0, 42/0, 43/1 (data/`tlast`); final beat valid exactly 16 cycles after 0x43 is accepted.
- Gap inside a character: `rx_busy` held high for 40 cycles after 0x10 → no `tlast`. The next byte 0x11 makes 0x10 go out with `tlast=0`.
- Length limit: `MAX_LEN=4`, 6 bytes 0..5 back-to-back → `tlast` on byte 3 and on byte 5 (the latter via timeout).
- Error flag: `rx_frame_error` pulse between bytes 2 and 3 of a 4-byte packet → `tuser=1` only on the `tlast` beat; the next packet has `tuser=0`.
- Backpressure: `m_axis_tready=0` for 50 cycles during a timeout.
  - `tlast` beat stays stable.
  - `s_axis_tready` drops once hold is full.
  - With stats enabled, a byte offered during the stall increments `drop_count` to 1.
- Reset mid-packet: `rst` asserted with 2 bytes buffered → outputs at reset values next cycle, and the next packet starts clean with `len_cnt=0`.
